// File: rtl/regmem_pkg.sv
// ---------------------------------------------------------------------------
// regmem_pkg
// Shared definitions for the RegisterMemory accumulate sequencer:
//   - seq_state_t   : sequencer FSM states
//   - FN_*          : RegisterMemory Select_Fn codes
//   - *_REG         : scratch register addresses (R0 accumulator, R1 operand,
//                     R2 ALU result)
//   - default carry-bit index and scratch-area ceiling
//   - small helpers that classify states as memory reads or writes
// ---------------------------------------------------------------------------
package regmem_pkg;

   // One state per bus cycle of the sequence; IDLE and DONE bracket a run.
   typedef enum logic [3:0] {
      S_IDLE,
      S_LD_RD,
      S_LD_WR,
      S_OP_RD,
      S_OP_WR,
      S_EXEC,
      S_EXEC_WAIT,
      S_RES_RD,
      S_RES_WR,
      S_OUT_RD,
      S_OUT_WR,
      S_DONE
   } seq_state_t;

   // RegisterMemory ALU function codes (R2 <= R0 fn R1).
   localparam logic [1:0] FN_ADD = 2'b00;
   localparam logic [1:0] FN_SUB = 2'b01;
   localparam logic [1:0] FN_AND = 2'b10;
   localparam logic [1:0] FN_OR  = 2'b11;

   // Scratch registers owned by the sequencer while a run is active.
   localparam int ACC_REG  = 0;
   localparam int OPND_REG = 1;
   localparam int RES_REG  = 2;

   localparam int CARRY_BIT_DEF   = 0;
   localparam int SCRATCH_TOP_DEF = 2;

   // States that issue a RegisterMemory read.
   function automatic logic is_read_state(input seq_state_t s);
      return (s == S_LD_RD) || (s == S_OP_RD) || (s == S_RES_RD) || (s == S_OUT_RD);
   endfunction

   // States that issue a RegisterMemory write.
   function automatic logic is_write_state(input seq_state_t s);
      return (s == S_LD_WR) || (s == S_OP_WR) || (s == S_RES_WR) || (s == S_OUT_WR);
   endfunction

endpackage

// File: rtl/regmem_port_mux.sv
// ---------------------------------------------------------------------------
// regmem_port_mux
// Decodes the sequencer state onto the RegisterMemory port. Purely
// combinational from the registered state, so every rm_* enable falls the
// moment the state register is reset.
// Ports:
//   state        in   current sequencer state
//   idx          in   AW    current operand register address
//   dest         in   AW    latched destination register
//   op           in   2     latched ALU function code
//   rm_data_out  in   DW    read data returned by RegisterMemory
//   rm_address   out  AW    RegisterMemory address (0 when idle)
//   rm_data_in   out  DW    RegisterMemory write data
//   rm_read_en   out  1     read strobe
//   rm_write_en  out  1     write strobe
//   rm_select_fn out  2     ALU function code (only meaningful with rm_fn_en)
//   rm_fn_en     out  1     execute strobe, high only in EXEC
// ---------------------------------------------------------------------------
module regmem_port_mux
   import regmem_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 5
) (
   input  seq_state_t     state,
   input  logic [AW-1:0]  idx,
   input  logic [AW-1:0]  dest,
   input  logic [1:0]     op,
   input  logic [DW-1:0]  rm_data_out,
   output logic [AW-1:0]  rm_address,
   output logic [DW-1:0]  rm_data_in,
   output logic           rm_read_en,
   output logic           rm_write_en,
   output logic [1:0]     rm_select_fn,
   output logic           rm_fn_en
);

   localparam logic [AW-1:0] ACC_A  = AW'(ACC_REG);
   localparam logic [AW-1:0] OPND_A = AW'(OPND_REG);
   localparam logic [AW-1:0] RES_A  = AW'(RES_REG);

   // Every write copies the word the previous read returned, so data_in is
   // simply the memory's own read data during write states.
   always_comb begin
      rm_address   = '0;
      rm_data_in   = '0;
      rm_read_en   = is_read_state(state);
      rm_write_en  = is_write_state(state);
      rm_select_fn = FN_ADD;
      rm_fn_en     = 1'b0;
      if (rm_write_en) begin
         rm_data_in = rm_data_out;
      end
      case (state)
         S_LD_RD:  rm_address = idx;
         S_LD_WR:  rm_address = ACC_A;
         S_OP_RD:  rm_address = idx;
         S_OP_WR:  rm_address = OPND_A;
         S_EXEC: begin
            rm_fn_en     = 1'b1;
            rm_select_fn = op;
         end
         S_RES_RD: rm_address = RES_A;
         S_RES_WR: rm_address = ACC_A;
         S_OUT_RD: rm_address = ACC_A;
         S_OUT_WR: rm_address = dest;
         default:  rm_address = '0;
      endcase
   end

endmodule

// File: rtl/regmem_accum_sequencer.sv
// ---------------------------------------------------------------------------
// regmem_accum_sequencer
// Folds one RegisterMemory ALU operation across registers
// first_addr..last_addr, leaving the result in dest_addr. R0 accumulates,
// R1 holds the operand, R2 receives each ALU result.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 one-cycle request, sampled only in IDLE
//   op                    ALU function for the whole run
//   first_addr/last_addr  inclusive operand range
//   dest_addr             destination of the final value
//   busy                  high for the whole run, low in DONE
//   done                  one-cycle pulse at end of run
//   error                 one-cycle pulse when a start is rejected
//   result                final value, held until overwritten by a later run
//   carry_count           saturating count of ALU steps that carried
//   rm_*                  RegisterMemory control/data port
// ---------------------------------------------------------------------------
module regmem_accum_sequencer
   import regmem_pkg::*;
#(
   parameter int DW          = 8,
   parameter int AW          = 5,
   parameter int FW          = 4,
   parameter int CARRY_BIT   = CARRY_BIT_DEF,
   parameter int SCRATCH_TOP = SCRATCH_TOP_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [AW-1:0]  first_addr,
   input  logic [AW-1:0]  last_addr,
   input  logic [AW-1:0]  dest_addr,
   output logic           busy,
   output logic           done,
   output logic           error,
   output logic [DW-1:0]  result,
   output logic [7:0]     carry_count,
   output logic [AW-1:0]  rm_address,
   output logic [DW-1:0]  rm_data_in,
   output logic           rm_read_en,
   output logic           rm_write_en,
   output logic [1:0]     rm_select_fn,
   output logic           rm_fn_en,
   input  logic [DW-1:0]  rm_data_out,
   input  logic [FW-1:0]  rm_flag
);

   localparam logic [AW-1:0] SCRATCH_LIM = AW'(SCRATCH_TOP);

   seq_state_t     state;
   logic [AW:0]    idx;
   logic [AW:0]    idx_inc;
   logic [AW:0]    last_ext;
   logic [AW-1:0]  last_q;
   logic [AW-1:0]  dest_q;
   logic [1:0]     op_q;
   logic           start_bad;
   logic           idx_past_end;
   logic           unused_flags;

   // idx carries one spare bit so stepping past register 31 is detectable
   // instead of wrapping back to 0.
   assign idx_inc      = idx + (AW+1)'(1);
   assign last_ext     = {1'b0, last_q};
   assign idx_past_end = idx_inc > last_ext;

   // A start is refused for an empty range or when either the operands or
   // the destination would overlap the scratch registers.
   assign start_bad = (first_addr > last_addr) ||
                      (first_addr <= SCRATCH_LIM) ||
                      (dest_addr <= SCRATCH_LIM);

   // Only the carry bit of the flag vector matters here.
   assign unused_flags = ^rm_flag;

   // Sequencer FSM: each state lasts one cycle. done and error default low
   // every cycle so they can only ever pulse. busy is raised on acceptance
   // and dropped on the way into DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         idx         <= '0;
         last_q      <= '0;
         dest_q      <= '0;
         op_q        <= FN_ADD;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         result      <= '0;
         carry_count <= '0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (start_bad) begin
                     error <= 1'b1;
                  end else begin
                     op_q        <= op;
                     last_q      <= last_addr;
                     dest_q      <= dest_addr;
                     idx         <= {1'b0, first_addr};
                     carry_count <= '0;
                     busy        <= 1'b1;
                     state       <= S_LD_RD;
                  end
               end
            end
            S_LD_RD: state <= S_LD_WR;
            S_LD_WR: begin
               idx   <= idx_inc;
               state <= idx_past_end ? S_OUT_RD : S_OP_RD;
            end
            S_OP_RD: state <= S_OP_WR;
            S_OP_WR: state <= S_EXEC;
            S_EXEC:  state <= S_EXEC_WAIT;
            S_EXEC_WAIT: begin
               if (rm_flag[CARRY_BIT] && (carry_count != 8'hFF)) begin
                  carry_count <= carry_count + 8'd1;
               end
               state <= S_RES_RD;
            end
            S_RES_RD: state <= S_RES_WR;
            S_RES_WR: begin
               idx   <= idx_inc;
               state <= idx_past_end ? S_OUT_RD : S_OP_RD;
            end
            S_OUT_RD: state <= S_OUT_WR;
            S_OUT_WR: begin
               result <= rm_data_out;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   regmem_port_mux #(
      .DW (DW),
      .AW (AW)
   ) u_port_mux (
      .state        (state),
      .idx          (idx[AW-1:0]),
      .dest         (dest_q),
      .op           (op_q),
      .rm_data_out  (rm_data_out),
      .rm_address   (rm_address),
      .rm_data_in   (rm_data_in),
      .rm_read_en   (rm_read_en),
      .rm_write_en  (rm_write_en),
      .rm_select_fn (rm_select_fn),
      .rm_fn_en     (rm_fn_en)
   );

endmodule

// File: tb/tb_regmem_accum_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regmem_accum_sequencer
// Directed bench for regmem_accum_sequencer with a behavioural RegisterMemory
// (32 x 8 registers, registered read data, R2 <= R0 fn R1 with carry in
// flag bit 0). Expected values below are worked out by hand.
// ---------------------------------------------------------------------------
module tb_regmem_accum_sequencer;
   import regmem_pkg::*;

   localparam int DW = 8;
   localparam int AW = 5;
   localparam int FW = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     op = 2'b00;
   logic [AW-1:0]  first_addr = '0;
   logic [AW-1:0]  last_addr = '0;
   logic [AW-1:0]  dest_addr = '0;
   logic           busy;
   logic           done;
   logic           error;
   logic [DW-1:0]  result;
   logic [7:0]     carry_count;
   logic [AW-1:0]  rm_address;
   logic [DW-1:0]  rm_data_in;
   logic           rm_read_en;
   logic           rm_write_en;
   logic [1:0]     rm_select_fn;
   logic           rm_fn_en;
   logic [DW-1:0]  rm_data_out = '0;
   logic [FW-1:0]  rm_flag = '0;

   logic [DW-1:0]  mem [0:31];
   logic           pre_we = 1'b0;
   logic [AW-1:0]  pre_addr = '0;
   logic [DW-1:0]  pre_data = '0;
   logic [DW:0]    alu_sum;

   int errors = 0;
   int checks = 0;
   int rd_total = 0;
   int wr_total = 0;
   int fn_total = 0;
   int overlap_count = 0;

   regmem_accum_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .op           (op),
      .first_addr   (first_addr),
      .last_addr    (last_addr),
      .dest_addr    (dest_addr),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .result       (result),
      .carry_count  (carry_count),
      .rm_address   (rm_address),
      .rm_data_in   (rm_data_in),
      .rm_read_en   (rm_read_en),
      .rm_write_en  (rm_write_en),
      .rm_select_fn (rm_select_fn),
      .rm_fn_en     (rm_fn_en),
      .rm_data_out  (rm_data_out),
      .rm_flag      (rm_flag)
   );

   always #5 clk = ~clk;

   // Behavioural RegisterMemory plus a bench-only preload port.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      if (rm_write_en) mem[rm_address] <= rm_data_in;
      if (rm_read_en) rm_data_out <= mem[rm_address];
      if (rm_fn_en) begin
         case (rm_select_fn)
            FN_ADD:  alu_sum = {1'b0, mem[0]} + {1'b0, mem[1]};
            FN_SUB:  alu_sum = {1'b0, mem[0]} - {1'b0, mem[1]};
            FN_AND:  alu_sum = {1'b0, mem[0] & mem[1]};
            default: alu_sum = {1'b0, mem[0] | mem[1]};
         endcase
         mem[2]  <= alu_sum[DW-1:0];
         rm_flag <= {{(FW-1){1'b0}}, alu_sum[DW]};
      end
   end

   // Bus activity counters and read/write overlap detector.
   always @(negedge clk) begin
      if (rm_read_en) rd_total++;
      if (rm_write_en) wr_total++;
      if (rm_fn_en) fn_total++;
      if (rm_read_en && rm_write_en) overlap_count++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = v;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   // Pulses start for one cycle; returns at the negedge after it was sampled.
   task automatic applyStimulus(input logic [1:0] o, input logic [AW-1:0] f,
                                input logic [AW-1:0] l, input logic [AW-1:0] d);
      @(negedge clk);
      op         = o;
      first_addr = f;
      last_addr  = l;
      dest_addr  = d;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic waitBusyEnd(output int cycles);
      cycles = 0;
      while (busy && cycles < 200) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic doRun(input string tag, input logic [1:0] o, input logic [AW-1:0] f,
                        input logic [AW-1:0] l, input logic [AW-1:0] d,
                        input int exp_cycles, input int exp_res, input int exp_carry);
      int cyc;
      applyStimulus(o, f, l, d);
      checkOutput({tag, "_busy_rise"}, busy, 1);
      waitBusyEnd(cyc);
      checkOutput({tag, "_busy_cycles"}, cyc, exp_cycles);
      checkOutput({tag, "_done"}, done, 1);
      checkOutput({tag, "_result"}, result, exp_res);
      checkOutput({tag, "_carry"}, carry_count, exp_carry);
      @(negedge clk);
      checkOutput({tag, "_done_drop"}, done, 0);
      checkOutput({tag, "_dest_mem"}, mem[d], exp_res);
   endtask

   initial begin
      int fn_before;
      int rd_before;
      int wr_before;
      int cyc;
      logic err_seen;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_error", error, 0);
      checkOutput("rst_result", result, 0);
      checkOutput("rst_carry", carry_count, 0);
      checkOutput("rst_addr", rm_address, 0);
      checkOutput("rst_enables", {rm_read_en, rm_write_en, rm_fn_en}, 0);
      rst_n = 1'b1;

      // 208*3 + 32*2 folded with wrap: 160(c), 112(c), 144, 176
      preload(5, 208); preload(6, 208); preload(7, 208);
      preload(8, 32);  preload(9, 32);
      fn_before = fn_total;
      doRun("sum5_9", FN_ADD, 5, 9, 13, 28, 176, 2);
      checkOutput("sum5_9_fn_pulses", fn_total - fn_before, 4);

      // Single-register range: copy only, no ALU step
      preload(4, 141);
      fn_before = fn_total;
      doRun("single4", FN_ADD, 4, 4, 10, 4, 141, 0);
      checkOutput("single4_fn_pulses", fn_total - fn_before, 0);

      // Rejected starts
      rd_before = rd_total;
      wr_before = wr_total;
      applyStimulus(FN_ADD, 9, 5, 13);
      checkOutput("rej_range_error", error, 1);
      checkOutput("rej_range_busy", busy, 0);
      @(negedge clk);
      checkOutput("rej_range_pulse", error, 0);
      applyStimulus(FN_ADD, 2, 9, 13);
      checkOutput("rej_first_error", error, 1);
      checkOutput("rej_first_busy", busy, 0);
      @(negedge clk);
      checkOutput("rej_first_pulse", error, 0);
      applyStimulus(FN_ADD, 5, 9, 1);
      checkOutput("rej_dest_error", error, 1);
      checkOutput("rej_dest_busy", busy, 0);
      @(negedge clk);
      checkOutput("rej_dest_pulse", error, 0);
      checkOutput("rej_no_reads", rd_total - rd_before, 0);
      checkOutput("rej_no_writes", wr_total - wr_before, 0);

      // start pulsed mid-run (with an otherwise-invalid request) is ignored
      applyStimulus(FN_ADD, 5, 9, 13);
      cyc = 0;
      err_seen = 1'b0;
      while (busy && cyc < 200) begin
         cyc++;
         if (cyc == 6) begin
            first_addr = 9;
            last_addr  = 5;
            start      = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         err_seen = err_seen | error;
      end
      start = 1'b0;
      checkOutput("midstart_busy_cycles", cyc, 28);
      checkOutput("midstart_no_error", err_seen, 0);
      checkOutput("midstart_done", done, 1);
      checkOutput("midstart_result", result, 176);
      checkOutput("midstart_carry", carry_count, 2);

      // Asynchronous reset during EXEC
      applyStimulus(FN_ADD, 5, 9, 14);
      repeat (4) @(negedge clk);
      checkOutput("exec_reached", rm_fn_en, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_fn_en", rm_fn_en, 0);
      checkOutput("arst_rd_wr", {rm_read_en, rm_write_en}, 0);
      checkOutput("arst_busy", busy, 0);
      checkOutput("arst_addr", rm_address, 0);
      @(negedge clk);
      rst_n = 1'b1;
      doRun("after_reset", FN_ADD, 5, 9, 14, 28, 176, 2);

      // Top of address space: 255+255 = 254(c), +255 = 253(c)
      preload(29, 255); preload(30, 255); preload(31, 255);
      doRun("wrap29_31", FN_ADD, 29, 31, 3, 16, 253, 2);

      checkOutput("rw_exclusive", overlap_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
